game_controller: RTL and testbench

//   Round-level FSM for the whack-a-mole game. It sits directly downstream of
//   the mole detector and consumes its OR-reduced hit/miss pulses.
//   It owns score, lives, round countdown and high score, and drives the

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_controller_if.sv | 30 +++
 rtl/game_controller_sec_tick_gen.sv | 43 ++++
 rtl/game_controller.sv | 125 ++++++++++++
 tb/tb_game_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole round controller: state encoding,
// LED period constants and the difficulty select decoder.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      PLAY      = 2'd2,
      OVER      = 2'd3
   } game_state_t;

   localparam logic [15:0] DIFF_EASY_MS = 16'd2000;
   localparam logic [15:0] DIFF_MED_MS  = 16'd1000;
   localparam logic [15:0] DIFF_HARD_MS = 16'd750;

   // Both low codes map to easy so an unplugged switch still gives a sane game.
   function automatic logic [15:0] decode_diff(input logic [1:0] diff_sel);
      case (diff_sel)
         2'b10:   decode_diff = DIFF_MED_MS;
         2'b11:   decode_diff = DIFF_HARD_MS;
         default: decode_diff = DIFF_EASY_MS;
      endcase
   endfunction

endpackage

// File: rtl/game_controller_if.sv
// Bundle of the controller's request inputs and status outputs. The master
// side is whoever feeds start/difficulty/hit/miss; the slave is the controller.
interface game_controller_if #(
   parameter int SCORE_W = 11
);
   logic               start_pulse;
   logic [1:0]         diff_sel;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               game_active;
   logic [15:0]        difficulty_ms;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] high_score;
   logic [1:0]         lives;
   logic [5:0]         time_left;
   logic [1:0]         state;
   logic               game_over_pulse;

   modport master (
      output start_pulse, diff_sel, hit_pulse, miss_pulse,
      input  game_active, difficulty_ms, score, high_score, lives,
             time_left, state, game_over_pulse
   );

   modport slave (
      input  start_pulse, diff_sel, hit_pulse, miss_pulse,
      output game_active, difficulty_ms, score, high_score, lives,
             time_left, state, game_over_pulse
   );
endinterface

// File: rtl/game_controller_sec_tick_gen.sv
// One-second strobe built from a millisecond prescaler and a millisecond
// counter. Both counters restart from zero whenever clear is asserted so every
// state begins with a full second.
module sec_tick_gen #(
   parameter int CLKS_PER_MS = 50000,
   parameter int MS_PER_S    = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic sec_tick
);
   localparam int MS_W = $clog2(CLKS_PER_MS + 1);
   localparam int S_W  = $clog2(MS_PER_S + 1);

   logic [MS_W-1:0] ms_cnt;
   logic [S_W-1:0]  s_cnt;
   logic            ms_wrap;
   logic            s_wrap;

   assign ms_wrap  = (ms_cnt == MS_W'(CLKS_PER_MS - 1));
   assign s_wrap   = (s_cnt == S_W'(MS_PER_S - 1));
   assign sec_tick = enable && ms_wrap && s_wrap;

   // Prescaler chain: ms_cnt wraps every millisecond and advances s_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_cnt <= '0;
         s_cnt  <= '0;
      end else if (clear) begin
         ms_cnt <= '0;
         s_cnt  <= '0;
      end else if (enable) begin
         if (ms_wrap) begin
            ms_cnt <= '0;
            s_cnt  <= s_wrap ? '0 : s_cnt + 1'b1;
         end else begin
            ms_cnt <= ms_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/game_controller.sv
// Round-level FSM for the whack-a-mole game: owns score, lives, the round
// countdown and the high score, and hands the difficulty period to the LED
// timer. Every status output comes straight from a register.
module game_controller
   import game_pkg::*;
#(
   parameter int CLKS_PER_MS = 50000,
   parameter int MS_PER_S    = 1000,
   parameter int COUNTDOWN_S = 3,
   parameter int GAME_S      = 30,
   parameter int START_LIVES = 3,
   parameter int SCORE_W     = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   game_controller_if.slave   bus
);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   game_state_t        state, state_next;
   logic [SCORE_W-1:0] score, score_next;
   logic [SCORE_W-1:0] high_score, high_next;
   logic [1:0]         lives, lives_next;
   logic [5:0]         time_left, time_next;
   logic [15:0]        diff_ms, diff_next;
   logic               game_active;
   logic               over_pulse;
   logic               entering;
   logic               sec_tick;

   assign entering = (state_next != state);

   sec_tick_gen #(
      .CLKS_PER_MS (CLKS_PER_MS),
      .MS_PER_S    (MS_PER_S)
   ) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (entering),
      .enable   ((state == COUNTDOWN) || (state == PLAY)),
      .sec_tick (sec_tick)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and next datapath values; a final hit or miss lands in the
   // same cycle as the move to OVER, so the high score sees the final score.
   always_comb begin
      state_next = state;
      score_next = score;
      lives_next = lives;
      time_next  = time_left;
      diff_next  = diff_ms;
      high_next  = high_score;
      case (state)
         IDLE, OVER: begin
            diff_next = decode_diff(bus.diff_sel);
            if (bus.start_pulse) begin
               state_next = COUNTDOWN;
               score_next = '0;
               lives_next = 2'(START_LIVES);
               time_next  = 6'(COUNTDOWN_S);
            end
         end
         COUNTDOWN: begin
            if (sec_tick) begin
               if (time_left == 6'd1) begin
                  state_next = PLAY;
                  time_next  = 6'(GAME_S);
               end else begin
                  time_next = time_left - 6'd1;
               end
            end
         end
         PLAY: begin
            if (bus.hit_pulse && (score != SCORE_MAX)) score_next = score + 1'b1;
            if (bus.miss_pulse && (lives != 2'd0)) begin
               lives_next = lives - 2'd1;
               if (lives == 2'd1) state_next = OVER;
            end
            if (sec_tick) begin
               time_next = time_left - 6'd1;
               if (time_left == 6'd1) state_next = OVER;
            end
         end
         default: state_next = IDLE;
      endcase
      if ((state_next == OVER) && (state != OVER) && (score_next > high_score))
         high_next = score_next;
   end

   // Datapath and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score       <= '0;
         high_score  <= '0;
         lives       <= 2'(START_LIVES);
         time_left   <= 6'(GAME_S);
         diff_ms     <= DIFF_EASY_MS;
         game_active <= 1'b0;
         over_pulse  <= 1'b0;
      end else begin
         score       <= score_next;
         high_score  <= high_next;
         lives       <= lives_next;
         time_left   <= time_next;
         diff_ms     <= diff_next;
         game_active <= (state_next == PLAY);
         over_pulse  <= (state_next == OVER) && (state != OVER);
      end
   end

   assign bus.state           = state;
   assign bus.score           = score;
   assign bus.high_score      = high_score;
   assign bus.lives           = lives;
   assign bus.time_left       = time_left;
   assign bus.difficulty_ms   = diff_ms;
   assign bus.game_active     = game_active;
   assign bus.game_over_pulse = over_pulse;
endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a 1 s = 8 cycle timebase. A second
// instance with a 2-bit score exercises saturation in a few hits.
module tb_game_controller;
   logic clk;
   logic rst_n;
   int   check_count;
   int   pass_count;
   int   pulse_count;
   int   pulse_base;

   game_controller_if #(.SCORE_W(11)) bus ();
   game_controller_if #(.SCORE_W(2))  bus_s ();

   game_controller #(
      .CLKS_PER_MS (2), .MS_PER_S (4), .COUNTDOWN_S (3),
      .GAME_S (5), .START_LIVES (3), .SCORE_W (11)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   game_controller #(
      .CLKS_PER_MS (2), .MS_PER_S (4), .COUNTDOWN_S (3),
      .GAME_S (5), .START_LIVES (3), .SCORE_W (2)
   ) dut_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every cycle in which the main instance reports game over.
   always @(negedge clk) begin
      if (bus.game_over_pulse) pulse_count = pulse_count + 1;
   end

   task automatic check_output(input string tag, input int unsigned observed,
                               input int unsigned expected);
      check_count = check_count + 1;
      if (observed == expected) pass_count = pass_count + 1;
      else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   // Advance n rising edges, then settle 1 ns past the edge.
   task automatic apply_stimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_round();
      bus.start_pulse = 1'b1;
      apply_stimulus(1);
      bus.start_pulse = 1'b0;
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      pulse_count = 0;
      rst_n = 1'b0;
      bus.start_pulse = 1'b0; bus.diff_sel = 2'b00;
      bus.hit_pulse = 1'b0;   bus.miss_pulse = 1'b0;
      bus_s.start_pulse = 1'b0; bus_s.diff_sel = 2'b00;
      bus_s.hit_pulse = 1'b0;   bus_s.miss_pulse = 1'b0;
      apply_stimulus(2);

      check_output("rst_state", 32'(bus.state), 0);
      check_output("rst_score", 32'(bus.score), 0);
      check_output("rst_high", 32'(bus.high_score), 0);
      check_output("rst_lives", 32'(bus.lives), 3);
      check_output("rst_time", 32'(bus.time_left), 5);
      check_output("rst_diff", 32'(bus.difficulty_ms), 2000);
      check_output("rst_active", 32'(bus.game_active), 0);
      rst_n = 1'b1;
      apply_stimulus(1);

      // Scenario 1: start, three-second countdown, then play.
      start_round();
      check_output("s1_countdown", 32'(bus.state), 1);
      check_output("s1_cd_time", 32'(bus.time_left), 3);
      apply_stimulus(23);
      check_output("s1_cd_last_state", 32'(bus.state), 1);
      check_output("s1_cd_last_time", 32'(bus.time_left), 1);
      check_output("s1_cd_inactive", 32'(bus.game_active), 0);
      apply_stimulus(1);
      check_output("s1_play", 32'(bus.state), 2);
      check_output("s1_play_time", 32'(bus.time_left), 5);
      check_output("s1_active", 32'(bus.game_active), 1);

      // Scenario 2: four hits, then the round runs out.
      bus.hit_pulse = 1'b1;
      apply_stimulus(4);
      bus.hit_pulse = 1'b0;
      check_output("s2_score4", 32'(bus.score), 4);
      apply_stimulus(35);
      check_output("s2_last_play", 32'(bus.state), 2);
      check_output("s2_last_time", 32'(bus.time_left), 1);
      check_output("s2_no_pulse_yet", 32'(pulse_count), 0);
      apply_stimulus(1);
      check_output("s2_over", 32'(bus.state), 3);
      check_output("s2_time0", 32'(bus.time_left), 0);
      check_output("s2_pulse", 32'(bus.game_over_pulse), 1);
      check_output("s2_high", 32'(bus.high_score), 4);
      check_output("s2_inactive", 32'(bus.game_active), 0);
      apply_stimulus(3);
      check_output("s2_pulse_once", 32'(pulse_count), 1);
      check_output("s2_pulse_low", 32'(bus.game_over_pulse), 0);
      check_output("s2_score_hold", 32'(bus.score), 4);

      // Scenario 3: restart from OVER and lose all lives.
      start_round();
      check_output("s3_restart", 32'(bus.state), 1);
      check_output("s3_score_clr", 32'(bus.score), 0);
      check_output("s3_lives", 32'(bus.lives), 3);
      apply_stimulus(24);
      check_output("s3_play", 32'(bus.state), 2);
      bus.miss_pulse = 1'b1; apply_stimulus(1); bus.miss_pulse = 1'b0;
      check_output("s3_lives2", 32'(bus.lives), 2);
      apply_stimulus(1);
      bus.miss_pulse = 1'b1; apply_stimulus(1); bus.miss_pulse = 1'b0;
      check_output("s3_lives1", 32'(bus.lives), 1);
      check_output("s3_still_play", 32'(bus.state), 2);
      bus.miss_pulse = 1'b1; apply_stimulus(1); bus.miss_pulse = 1'b0;
      check_output("s3_lives0", 32'(bus.lives), 0);
      check_output("s3_over", 32'(bus.state), 3);
      check_output("s3_high_keep", 32'(bus.high_score), 4);

      // Scenario 4: final miss with a simultaneous hit that beats the record.
      start_round();
      apply_stimulus(24);
      bus.hit_pulse = 1'b1; apply_stimulus(4); bus.hit_pulse = 1'b0;
      bus.miss_pulse = 1'b1; apply_stimulus(2);
      check_output("s4_lives1", 32'(bus.lives), 1);
      bus.hit_pulse = 1'b1; apply_stimulus(1);
      bus.hit_pulse = 1'b0; bus.miss_pulse = 1'b0;
      check_output("s4_score5", 32'(bus.score), 5);
      check_output("s4_lives0", 32'(bus.lives), 0);
      check_output("s4_over", 32'(bus.state), 3);
      check_output("s4_high5", 32'(bus.high_score), 5);

      // Final miss on the same cycle as the last second: one game over only.
      start_round();
      apply_stimulus(24);
      pulse_base = pulse_count;
      bus.miss_pulse = 1'b1; apply_stimulus(2); bus.miss_pulse = 1'b0;
      apply_stimulus(37);
      check_output("s4b_time1", 32'(bus.time_left), 1);
      check_output("s4b_lives1", 32'(bus.lives), 1);
      bus.miss_pulse = 1'b1; apply_stimulus(1); bus.miss_pulse = 1'b0;
      check_output("s4b_over", 32'(bus.state), 3);
      check_output("s4b_lives0", 32'(bus.lives), 0);
      check_output("s4b_time0", 32'(bus.time_left), 0);
      apply_stimulus(3);
      check_output("s4b_one_pulse", 32'(pulse_count - pulse_base), 1);
      check_output("s4b_high_keep", 32'(bus.high_score), 5);

      // Scenario 5: 2-bit score saturates at 3.
      bus_s.start_pulse = 1'b1; apply_stimulus(1); bus_s.start_pulse = 1'b0;
      apply_stimulus(24);
      check_output("s5_play", 32'(bus_s.state), 2);
      bus_s.hit_pulse = 1'b1; apply_stimulus(3);
      check_output("s5_score_max", 32'(bus_s.score), 3);
      apply_stimulus(2); bus_s.hit_pulse = 1'b0;
      check_output("s5_saturated", 32'(bus_s.score), 3);

      // Scenario 6: difficulty select, freeze in play, asynchronous reset.
      rst_n = 1'b0; #1;
      rst_n = 1'b1;
      apply_stimulus(1);
      check_output("s6_easy", 32'(bus.difficulty_ms), 2000);
      bus.diff_sel = 2'b10; apply_stimulus(1);
      check_output("s6_medium", 32'(bus.difficulty_ms), 1000);
      bus.diff_sel = 2'b11; apply_stimulus(1);
      check_output("s6_hard", 32'(bus.difficulty_ms), 750);
      start_round();
      bus.diff_sel = 2'b10;
      apply_stimulus(24);
      check_output("s6_play", 32'(bus.state), 2);
      check_output("s6_frozen", 32'(bus.difficulty_ms), 750);
      bus.hit_pulse = 1'b1; apply_stimulus(2); bus.hit_pulse = 1'b0;
      check_output("s6_score2", 32'(bus.score), 2);
      #2;
      rst_n = 1'b0; #1;
      check_output("s6_rst_state", 32'(bus.state), 0);
      check_output("s6_rst_active", 32'(bus.game_active), 0);
      check_output("s6_rst_score", 32'(bus.score), 0);
      check_output("s6_rst_high", 32'(bus.high_score), 0);
      check_output("s6_rst_lives", 32'(bus.lives), 3);
      check_output("s6_rst_time", 32'(bus.time_left), 5);
      check_output("s6_rst_diff", 32'(bus.difficulty_ms), 2000);
      check_output("s6_rst_small", 32'(bus_s.score), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
